// File: rtl/dcache_pkg.sv
// Shared widths and FSM state type for the n-way write-back data cache.
package dcache_pkg;

    localparam int ADDR_W   = 32;
    localparam int WORD_W   = 32;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;
    localparam int WSEL_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2,
        ST_FILL      = 2'd3
    } state_e;

endpackage

// File: rtl/dcache_way.sv
// One cache way: per-set valid/dirty/tag/line storage with asynchronous read
// and a single write port shared by line refill and word store.
module dcache_way
    import dcache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 23
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o,
    input  logic              fill_i,
    input  logic [TAG_W-1:0]  fill_tag_i,
    input  logic [LINE_W-1:0] fill_line_i,
    input  logic              store_i,
    input  logic [WSEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0] word_i
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (store_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data need no reset: valid gates every use of them.
    always_ff @(posedge clk_i) begin
        if (fill_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (store_i) begin
            data_q[idx_i][{word_sel_i, 5'b0} +: WORD_W] <= word_i;
        end
    end

endmodule

// File: rtl/dcache_nway.sv
// N-way set-associative write-back/write-allocate data cache controller.
// Optional hit/miss statistics counters are enabled by DCACHE_STATS_EN.
module dcache_nway
    import dcache_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [WAY_W-1:0]  rr_q [SETS];

    logic              req;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  lk_idx;
    logic [WSEL_W-1:0] word_sel;

    logic [WAYS-1:0]   way_valid, way_dirty, way_fill, way_store;
    logic [TAG_W-1:0]  way_tag  [WAYS];
    logic [LINE_W-1:0] way_line [WAYS];

    logic              hit;
    logic [WAY_W-1:0]  hit_way, vic_way, sel_way, rr_next;
    logic              stall, fill_en, store_en, cnt_hit, cnt_miss;
    logic              mem_en, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_data;
    logic [WORD_W-1:0] rd_data;
    logic              unused_addr_bits;

    assign req      = p1_MemRead_i | p1_MemWrite_i;
    assign req_tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign req_idx  = p1_addr_i[OFFSET_W +: IDX_W];
    assign word_sel = p1_addr_i[OFFSET_W-1:2];
    assign lk_idx   = (state_q == ST_IDLE) ? req_idx : idx_q;
    assign unused_addr_bits = ^p1_addr_i[1:0];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        dcache_way #(
            .SETS (SETS),
            .IDX_W(IDX_W),
            .TAG_W(TAG_W)
        ) u_way (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .idx_i      (lk_idx),
            .valid_o    (way_valid[w]),
            .dirty_o    (way_dirty[w]),
            .tag_o      (way_tag[w]),
            .line_o     (way_line[w]),
            .fill_i     (way_fill[w]),
            .fill_tag_i (tag_q),
            .fill_line_i(mem_data_i),
            .store_i    (way_store[w]),
            .word_sel_i (word_sel),
            .word_i     (p1_data_i)
        );
    end

    // Descending scans so the lowest matching / lowest invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic_way = rr_q[req_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_valid[w] && (way_tag[w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!way_valid[w]) begin
                vic_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tag_d    = tag_q;
        victim_d = victim_q;
        stall    = 1'b0;
        fill_en  = 1'b0;
        store_en = 1'b0;
        cnt_hit  = 1'b0;
        cnt_miss = 1'b0;
        mem_en   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        rd_data  = '0;
        sel_way  = (state_q == ST_FILL) ? victim_q : hit_way;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (hit) begin
                        rd_data  = way_line[sel_way][{word_sel, 5'b0} +: WORD_W];
                        store_en = p1_MemWrite_i;
                        cnt_hit  = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        cnt_miss = 1'b1;
                        idx_d    = req_idx;
                        tag_d    = req_tag;
                        victim_d = vic_way;
                        state_d  = (way_valid[vic_way] && way_dirty[vic_way]) ?
                                   ST_WRITEBACK : ST_ALLOCATE;
                    end
                end
            end
            ST_WRITEBACK: begin
                stall    = 1'b1;
                mem_en   = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = {way_tag[victim_q], idx_q, {OFFSET_W{1'b0}}};
                mem_data = way_line[victim_q];
                if (mem_ack_i) state_d = ST_ALLOCATE;
            end
            ST_ALLOCATE: begin
                stall    = 1'b1;
                mem_en   = 1'b1;
                mem_addr = {tag_q, idx_q, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    fill_en = 1'b1;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                // Line was written at the ack edge; serve the held request as a hit.
                if (req) begin
                    rd_data  = way_line[sel_way][{word_sel, 5'b0} +: WORD_W];
                    store_en = p1_MemWrite_i;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        way_fill  = '0;
        way_store = '0;
        if (fill_en)  way_fill[victim_q] = 1'b1;
        if (store_en) way_store[sel_way] = 1'b1;
    end

    assign rr_next = (rr_q[idx_q] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx_q] + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            tag_q    <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tag_q    <= tag_d;
            victim_q <= victim_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (fill_en) begin
            rr_q[idx_q] <= rr_next;
        end
    end

    // Outputs are forced quiet while reset is asserted, even mid-transaction.
    assign p1_stall_o   = !rst_i && stall;
    assign p1_data_o    = rst_i ? '0 : rd_data;
    assign mem_enable_o = !rst_i && mem_en;
    assign mem_write_o  = !rst_i && mem_wr;
    assign mem_addr_o   = rst_i ? '0 : mem_addr;
    assign mem_data_o   = rst_i ? '0 : mem_data;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (cnt_hit && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (cnt_miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = rst_i ? '0 : hit_cnt_q;
    assign miss_cnt_o = rst_i ? '0 : miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = cnt_hit ^ cnt_miss;
    assign hit_cnt_o    = '0;
    assign miss_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway (WAYS=2, SETS=16): refill, eviction order,
// write-back contents, store/load priority and reset abandoning a refill.
module tb_dcache_nway;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic         p1_MemRead_i;
    logic         p1_MemWrite_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    int checks = 0;
    int errors = 0;

    dcache_nway #(.WAYS(2), .SETS(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_MemRead_i (p1_MemRead_i),
        .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .mem_data_o   (mem_data_o),
        .mem_addr_o   (mem_addr_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [255:0] line, input logic [31:0] addr);
        return line[{addr[4:2], 5'b0} +: 32];
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        cyc();
        cyc();
        rst_i = 1'b0;
    endtask

    // Waits (bounded) for a memory request, checks it, returns the write line, acks it.
    task automatic mem_txn(input string tag, input logic [31:0] exp_addr, input logic exp_wr,
                           input logic [255:0] rline, output logic [255:0] wline);
        int n = 0;
        #1;
        while (mem_enable_o !== 1'b1 && n < 20) begin
            cyc();
            #1;
            n++;
        end
        check({tag, "_en"}, mem_enable_o, 1'b1);
        check({tag, "_addr"}, mem_addr_o, exp_addr);
        check({tag, "_wr"}, mem_write_o, exp_wr);
        check({tag, "_stall"}, p1_stall_o, 1'b1);
        wline = mem_data_o;
        mem_data_i = rline;
        mem_ack_i = 1'b1;
        cyc();
        mem_ack_i = 1'b0;
        mem_data_i = '0;
    endtask

    task automatic load_miss(input string tag, input logic [31:0] addr, input logic [255:0] line);
        logic [255:0] wl;
        p1_addr_i = addr;
        p1_MemRead_i = 1'b1;
        #1;
        check({tag, "_miss_stall"}, p1_stall_o, 1'b1);
        cyc();
        mem_txn({tag, "_alloc"}, {addr[31:5], 5'b0}, 1'b0, line, wl);
        #1;
        check({tag, "_fill_stall"}, p1_stall_o, 1'b0);
        check({tag, "_fill_data"}, p1_data_o, word_of(line, addr));
        check({tag, "_fill_en"}, mem_enable_o, 1'b0);
        cyc();
        p1_MemRead_i = 1'b0;
    endtask

    task automatic load_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        p1_addr_i = addr;
        p1_MemRead_i = 1'b1;
        #1;
        check({tag, "_stall"}, p1_stall_o, 1'b0);
        check({tag, "_data"}, p1_data_o, exp);
        cyc();
        p1_MemRead_i = 1'b0;
    endtask

    logic [255:0] line_a, line_b, line_c, line_d, line_e, line_1, wb_line;
    logic [31:0]  exp_hits, exp_misses;

    initial begin
        line_a = make_line(32'hA000_0000);
        line_b = make_line(32'hB000_0000);
        line_c = make_line(32'hC000_0000);
        line_d = make_line(32'hD000_0000);
        line_e = make_line(32'hE000_0000);
        line_1 = make_line(32'h1000_0000);
        line_1[95:64] = 32'hDEAD_BEEF;
        p1_addr_i = '0;
        p1_data_i = '0;

        // Reset: everything quiet during and after.
        rst_i = 1'b1;
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        cyc();
        #1;
        check("rst_stall", p1_stall_o, 1'b0);
        check("rst_data", p1_data_o, 32'h0);
        check("rst_en", mem_enable_o, 1'b0);
        check("rst_wr", mem_write_o, 1'b0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_mdata", mem_data_o, 256'h0);
        check("rst_hit", hit_cnt_o, 32'h0);
        check("rst_miss", miss_cnt_o, 32'h0);
        cyc();
        rst_i = 1'b0;
        #1;
        check("post_rst_stall", p1_stall_o, 1'b0);
        check("post_rst_en", mem_enable_o, 1'b0);

        // Load 0x40 misses; FILL serves word 2 of the same line.
        p1_addr_i = 32'h40;
        p1_MemRead_i = 1'b1;
        #1;
        check("t1_miss_stall", p1_stall_o, 1'b1);
        check("t1_idle_en", mem_enable_o, 1'b0);
        cyc();
        #1;
        check("t1_alloc_en", mem_enable_o, 1'b1);
        check("t1_alloc_addr", mem_addr_o, 32'h40);
        check("t1_alloc_wr", mem_write_o, 1'b0);
        cyc();
        #1;
        check("t1_wait_en", mem_enable_o, 1'b1);
        check("t1_wait_stall", p1_stall_o, 1'b1);
        mem_data_i = line_1;
        mem_ack_i = 1'b1;
        #1;
        check("t1_ack_stall", p1_stall_o, 1'b1);
        cyc();
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        p1_addr_i = 32'h48;
        #1;
        check("t1_fill_stall", p1_stall_o, 1'b0);
        check("t1_fill_data", p1_data_o, 32'hDEAD_BEEF);
        check("t1_fill_en", mem_enable_o, 1'b0);
        cyc();
        p1_MemRead_i = 1'b0;
        load_hit("t1_hit", 32'h44, 32'h1000_0001);

        // Two misses, a hit, then a third tag evicts way 0.
        do_reset();
        load_miss("t2_a", 32'h000, line_a);
        load_miss("t2_b", 32'h200, line_b);
        load_hit("t2_hit_a", 32'h000, 32'hA000_0000);
        load_miss("t2_c", 32'h400, line_c);
`ifdef DCACHE_STATS_EN
        exp_hits = 32'd1;
        exp_misses = 32'd3;
`else
        exp_hits = 32'd0;
        exp_misses = 32'd0;
`endif
        #1;
        check("t2_hit_cnt", hit_cnt_o, exp_hits);
        check("t2_miss_cnt", miss_cnt_o, exp_misses);
        load_hit("t2_b_kept", 32'h20C, 32'hB000_0003);

        // Dirty victim is written back before the refill.
        do_reset();
        load_miss("t3_a", 32'h000, line_a);
        p1_addr_i = 32'h000;
        p1_data_i = 32'h1234_5678;
        p1_MemWrite_i = 1'b1;
        #1;
        check("t3_store_stall", p1_stall_o, 1'b0);
        cyc();
        p1_MemWrite_i = 1'b0;
        load_hit("t3_readback", 32'h000, 32'h1234_5678);
        load_miss("t3_b", 32'h200, line_b);
        p1_addr_i = 32'h400;
        p1_MemRead_i = 1'b1;
        #1;
        check("t3_evict_stall", p1_stall_o, 1'b1);
        cyc();
        mem_txn("t3_wb", 32'h000, 1'b1, 256'h0, wb_line);
        check("t3_wb_word0", wb_line[31:0], 32'h1234_5678);
        check("t3_wb_word1", wb_line[63:32], 32'hA000_0001);
        mem_txn("t3_alloc", 32'h400, 1'b0, line_c, wb_line);
        #1;
        check("t3_fill_stall", p1_stall_o, 1'b0);
        check("t3_fill_data", p1_data_o, 32'hC000_0000);
        cyc();
        p1_MemRead_i = 1'b0;

        // Read and write together: store wins and leaves the line dirty.
        p1_addr_i = 32'h10;
        p1_data_i = 32'hCAFE_F00D;
        p1_MemRead_i = 1'b1;
        p1_MemWrite_i = 1'b1;
        #1;
        check("t4_miss_stall", p1_stall_o, 1'b1);
        cyc();
        mem_txn("t4_alloc", 32'h000, 1'b0, line_d, wb_line);
        #1;
        check("t4_fill_stall", p1_stall_o, 1'b0);
        cyc();
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
        load_hit("t4_readback", 32'h10, 32'hCAFE_F00D);
        load_hit("t4_other_word", 32'h0C, 32'hD000_0003);
        load_miss("t4_b", 32'h200, line_b);
        p1_addr_i = 32'h400;
        p1_MemRead_i = 1'b1;
        #1;
        check("t4_evict_stall", p1_stall_o, 1'b1);
        cyc();
        mem_txn("t4_wb", 32'h000, 1'b1, 256'h0, wb_line);
        check("t4_wb_word4", wb_line[159:128], 32'hCAFE_F00D);
        check("t4_wb_word0", wb_line[31:0], 32'hD000_0000);
        mem_txn("t4_alloc_c", 32'h400, 1'b0, line_c, wb_line);
        cyc();
        p1_MemRead_i = 1'b0;

        // Reset during ALLOCATE abandons the refill; a late ack is ignored.
        do_reset();
        p1_addr_i = 32'h80;
        p1_MemRead_i = 1'b1;
        #1;
        check("t5_miss_stall", p1_stall_o, 1'b1);
        cyc();
        #1;
        check("t5_alloc_en", mem_enable_o, 1'b1);
        rst_i = 1'b1;
        p1_MemRead_i = 1'b0;
        #1;
        check("t5_rst_en", mem_enable_o, 1'b0);
        check("t5_rst_stall", p1_stall_o, 1'b0);
        check("t5_rst_addr", mem_addr_o, 32'h0);
        cyc();
        rst_i = 1'b0;
        mem_data_i = line_e;
        mem_ack_i = 1'b1;
        #1;
        check("t5_late_ack_en", mem_enable_o, 1'b0);
        check("t5_late_ack_stall", p1_stall_o, 1'b0);
        cyc();
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        #1;
        check("t5_after_ack_en", mem_enable_o, 1'b0);
        load_miss("t5_again", 32'h84, line_e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_nway.md
DCACHE_NWAY -- requirements
Module: dcache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity (power of two, 1..8).
REQ-002 SHALL have parameter SETS, default 16, number of sets (power of two, 2..256).
REQ-003 SHALL have fixed geometry: 32-bit address, 32-bit CPU word, 256-bit line, 5-bit byte offset, word select addr[4:2], index addr[5+log2(SETS)-1:5], remaining upper bits tag.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  clock, all state updates on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 p1_addr_i  in  32  CPU byte address.
REQ-008 p1_data_i  in  32  CPU store data.
REQ-009 p1_MemRead_i  in  1  load request.
REQ-010 p1_MemWrite_i  in  1  store request.
REQ-011 p1_data_o  out  32  load data.
REQ-012 p1_stall_o  out  1  CPU must hold the pipeline and the request stable while high.
REQ-013 mem_data_i  in  256  refill line; mem_ack_i  in  1  one-cycle completion pulse.
REQ-014 mem_data_o  out  256  victim line; mem_addr_o  out  32  line-aligned address; mem_enable_o  out  1  request; mem_write_o  out  1  1=write-back, 0=refill.
REQ-015 hit_cnt_o  out  32  hit count; miss_cnt_o  out  32  miss count.

Function
REQ-016 SHALL be write-back, write-allocate; each way per set holds valid, dirty, tag, 256-bit data.
REQ-017 SHALL give MemWrite priority when MemRead and MemWrite are both high.
REQ-018 SHALL on hit in IDLE drive p1_data_o combinationally the same cycle, p1_stall_o=0; store hit updates the selected word and sets dirty at the next edge.
REQ-019 SHALL on miss raise p1_stall_o combinationally the same cycle and keep it high until the completing cycle.
REQ-020 SHALL use FSM IDLE -> (miss, victim dirty) WRITEBACK -> ALLOCATE -> FILL -> IDLE; clean victim goes IDLE -> ALLOCATE.
REQ-021 SHALL in WRITEBACK assert mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag,index,5'b0}, mem_data_o=victim line until mem_ack_i; then ALLOCATE.
REQ-022 SHALL in ALLOCATE assert mem_enable_o=1, mem_write_o=0, mem_addr_o={request tag,index,5'b0} until mem_ack_i; on ack write mem_data_i into victim way, valid=1, dirty=0, go FILL.
REQ-023 SHALL in FILL serve the access as a hit (stall low, store merges word and sets dirty), returning to IDLE next edge; miss penalty = memory latency(s) + 1 cycle.
REQ-024 SHALL select victim as lowest-index invalid way, else per-set round-robin pointer, which advances (mod WAYS) on each allocation into that set.
REQ-025 SHALL ignore mem_ack_i when mem_enable_o is low; mem_enable_o drops the cycle after ack.
REQ-026 SHALL latch index/tag/victim at the IDLE->miss transition; requests absent (both enables low) cause no state change.
REQ-027 WAYS=1 SHALL behave as a direct-mapped cache with identical timing.

Reset
REQ-028 SHALL on rst_i clear all valid and dirty bits, round-robin pointers and counters, force IDLE, including mid-WRITEBACK/ALLOCATE (the pending memory transaction is abandoned).
REQ-029 SHALL drive during and after reset: p1_stall_o=0, p1_data_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, hit_cnt_o=0, miss_cnt_o=0.

Configuration
REQ-030 With DCACHE_STATS_EN defined, hit_cnt_o/miss_cnt_o SHALL count accepted hits (IDLE only) and misses (once per miss), saturating at 32'hFFFFFFFF; without it both are constant 0 and no counter flops exist.

Structure
REQ-031 Shared package dcache_pkg SHALL hold the FSM state typedef, line/word/address width constants and the offset width.
REQ-032 Tag/valid/dirty/data storage per way SHALL be a sub-module dcache_way, instantiated WAYS times; FSM, victim select and counters stay in dcache_nway.

Verification
REQ-033 Load 0x0000_0040 after reset: stall, ALLOCATE addr 0x40 write=0; ack with line word2=0xDEAD_BEEF, load 0x48 -> 0xDEAD_BEEF, stall 0 in FILL.
REQ-034 WAYS=2, SETS=16: loads 0x000, 0x200, 0x000 -> two misses then hit; third tag 0x400 evicts way 0 (round-robin) -> miss_cnt=3, hit_cnt=1.
REQ-035 Store 0x1234_5678 to 0x000 (hit), then force eviction -> WRITEBACK addr 0x000 write=1, mem_data_o[31:0]=0x1234_5678, then ALLOCATE.
REQ-036 Simultaneous MemRead and MemWrite to 0x10 -> store performed, line dirty.
REQ-037 rst_i mid-ALLOCATE, late ack arrives -> ack ignored, mem_enable_o=0, next access to same address misses.
